// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD types and digit helpers for the decimal datapath.
// Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] nibble);
        return (nibble <= 4'd9);
    endfunction

    // Returns {carry_out, sum_digit}; adding 6 skips the six unused codes.
    function automatic logic [DIGIT_W:0] bcd_digit_add(
        input logic [DIGIT_W-1:0] a,
        input logic [DIGIT_W-1:0] b,
        input logic               cin
    );
        logic [DIGIT_W:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9) begin
            return {1'b1, 4'(s + 5'd6)};
        end
        return {1'b0, s[DIGIT_W-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mul_by_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mul_by_digit
// Description : Combinational multiply of a DIGITS-digit BCD word by one digit.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_mul_by_digit
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGIT_W*DIGITS-1:0]     x,
    input  logic [DIGIT_W-1:0]            d,
    output logic [DIGIT_W*(DIGITS+1)-1:0] p
);

    logic [DIGIT_W*(DIGITS+1)-1:0] w_x_ext;
    logic [6:0]                    w_prod;
    logic [DIGIT_W-1:0]            w_lo;
    logic [DIGIT_W-1:0]            w_hi;
    logic [DIGIT_W-1:0]            w_hi_prev;
    logic [DIGIT_W:0]              w_dsum;
    logic                          w_carry;

    assign w_x_ext = {{DIGIT_W{1'b0}}, x};

    // Digit k of the result is the ones digit of x[k]*d plus the tens digit
    // of x[k-1]*d, with a rippled decimal carry. The top carry is always 0.
    always_comb begin
        p         = '0;
        w_prod    = '0;
        w_lo      = '0;
        w_hi      = '0;
        w_hi_prev = '0;
        w_dsum    = '0;
        w_carry   = 1'b0;
        for (int k = 0; k <= DIGITS; k++) begin
            w_prod    = {3'b000, w_x_ext[DIGIT_W*k +: DIGIT_W]} * {3'b000, d};
            w_lo      = 4'(w_prod % 7'd10);
            w_hi      = 4'(w_prod / 7'd10);
            w_dsum    = bcd_digit_add(w_lo, w_hi_prev, w_carry);
            w_carry   = w_dsum[DIGIT_W];
            p[DIGIT_W*k +: DIGIT_W] = w_dsum[DIGIT_W-1:0];
            w_hi_prev = w_hi;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mult_seq
// Description : Digit-serial packed-BCD multiplier, one multiplier digit/cycle.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_mult_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DIGIT_W*DIGITS-1:0]   x_bcd,
    input  logic [DIGIT_W*DIGITS-1:0]   y_bcd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*DIGIT_W*DIGITS-1:0] product,
    output logic                        err
);

    localparam int c_xw    = DIGIT_W * DIGITS;
    localparam int c_aw    = 2 * c_xw;
    localparam int c_pw    = c_xw + DIGIT_W;
    localparam int c_cnt_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [c_xw-1:0]    r_x;
    logic [c_xw-1:0]    r_y;
    logic [c_aw-1:0]    r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    logic               w_bad;
    logic [c_pw-1:0]    w_pp;
    logic [c_aw-1:0]    w_acc_shift;
    logic [c_aw-1:0]    w_pp_ext;
    logic [c_aw-1:0]    w_acc_next;
    logic [DIGIT_W:0]   w_dsum;
    logic               w_carry;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_acc;
    assign err       = r_err;

    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!bcd_valid(x_bcd[DIGIT_W*k +: DIGIT_W]) ||
                !bcd_valid(y_bcd[DIGIT_W*k +: DIGIT_W])) begin
                w_bad = 1'b1;
            end
        end
    end

    // r_y shifts left each MUL cycle so its top digit is always y[i].
    bcd_mul_by_digit #(
        .DIGITS (DIGITS)
    ) u_mul_by_digit (
        .x (r_x),
        .d (r_y[c_xw-1 -: DIGIT_W]),
        .p (w_pp)
    );

    assign w_acc_shift = {r_acc[c_aw-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
    assign w_pp_ext    = {{(c_aw-c_pw){1'b0}}, w_pp};

    always_comb begin
        w_acc_next = '0;
        w_dsum     = '0;
        w_carry    = 1'b0;
        for (int k = 0; k < 2*DIGITS; k++) begin
            w_dsum  = bcd_digit_add(w_acc_shift[DIGIT_W*k +: DIGIT_W],
                                    w_pp_ext[DIGIT_W*k +: DIGIT_W], w_carry);
            w_carry = w_dsum[DIGIT_W];
            w_acc_next[DIGIT_W*k +: DIGIT_W] = w_dsum[DIGIT_W-1:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)     w_state_next = w_bad ? DONE : MUL;
            MUL:     if (r_cnt == '0)  w_state_next = DONE;
            DONE:    if (out_ready)    w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x   <= x_bcd;
                        r_y   <= y_bcd;
                        r_acc <= '0;
                        r_cnt <= c_cnt_w'(DIGITS - 1);
                        r_err <= w_bad;
                    end
                end
                MUL: begin
                    r_acc <= w_acc_next;
                    r_y   <= {r_y[c_xw-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
                    r_cnt <= r_cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_mult_seq
// Description : Self-checking bench for bcd_mult_seq at DIGITS=4 and DIGITS=8.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, err4;
    logic [15:0] x4, y4;
    logic [31:0] prod4;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, err8;
    logic [31:0] x8, y8;
    logic [63:0] prod8;

    bcd_mult_seq #(.DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .x_bcd(x4), .y_bcd(y4), .out_valid(out_valid4), .out_ready(out_ready4),
        .product(prod4), .err(err4)
    );

    bcd_mult_seq #(.DIGITS(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .x_bcd(x8), .y_bcd(y8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(prod8), .err(err8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: plain decimal arithmetic ------------
    function automatic logic [63:0] bcd_to_int(input logic [63:0] b, input int nd);
        logic [63:0] v = 64'd0;
        for (int i = nd - 1; i >= 0; i--) v = v * 64'd10 + 64'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [63:0] int_to_bcd(input logic [63:0] v, input int nd);
        logic [63:0] r = 64'd0;
        logic [63:0] t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 64'd10);
            t = t / 64'd10;
        end
        return r;
    endfunction

    function automatic logic ref_err(input logic [63:0] x, input logic [63:0] y, input int nd);
        logic bad = 1'b0;
        for (int i = 0; i < nd; i++)
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [63:0] ref_prod(input logic [63:0] x, input logic [63:0] y, input int nd);
        if (ref_err(x, y, nd)) return 64'd0;
        return int_to_bcd(bcd_to_int(x, nd) * bcd_to_int(y, nd), 2 * nd);
    endfunction

    function automatic logic [63:0] rand_bcd(input int nd);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // ---------------- DUT access helpers (sel 0 = 4 digits, 1 = 8 digits) --
    function automatic logic get_ir(input int sel);
        return (sel == 0) ? in_ready4 : in_ready8;
    endfunction
    function automatic logic get_ov(input int sel);
        return (sel == 0) ? out_valid4 : out_valid8;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? err4 : err8;
    endfunction
    function automatic logic [63:0] get_prod(input int sel);
        return (sel == 0) ? {32'd0, prod4} : prod8;
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [63:0] x, input logic [63:0] y);
        if (sel == 0) begin
            in_valid4 = v; x4 = x[15:0]; y4 = y[15:0];
        end else begin
            in_valid8 = v; x8 = x[31:0]; y8 = y[31:0];
        end
    endtask

    task automatic set_oready(input int sel, input logic v);
        if (sel == 0) out_ready4 = v;
        else          out_ready8 = v;
    endtask

    // One complete job; lat = edges from accept edge until out_valid is seen.
    task automatic run_job(input int sel, input logic [63:0] x, input logic [63:0] y,
                           output logic [63:0] p, output logic e, output int lat);
        int n = 0;
        while (!get_ir(sel) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!get_ir(sel)) check("in_ready timeout", 64'(get_ir(sel)), 64'd1);
        drive_in(sel, 1'b1, x, y);
        @(posedge clk); #1;
        drive_in(sel, 1'b0, x, y);
        lat = 0;
        while (!get_ov(sel) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!get_ov(sel)) check("out_valid timeout", 64'(get_ov(sel)), 64'd1);
        p = get_prod(sel);
        e = get_err(sel);
        set_oready(sel, 1'b1);
        @(posedge clk); #1;
        set_oready(sel, 1'b0);
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] p;
        logic        e;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p, x, y;
        logic        e;
        int          lat;

        vecs[0] = '{16'h1234, 16'h5678, 32'h07006652, 1'b0};
        vecs[1] = '{16'h9999, 16'h9999, 32'h99980001, 1'b0};
        vecs[2] = '{16'h0000, 16'h4321, 32'h00000000, 1'b0};
        vecs[3] = '{16'h12A4, 16'h5555, 32'h00000000, 1'b1};
        vecs[4] = '{16'h0002, 16'h0003, 32'h00000006, 1'b0};
        vecs[5] = '{16'h0025, 16'h0004, 32'h00000100, 1'b0};
        vecs[6] = '{16'h0001, 16'h00F0, 32'h00000000, 1'b1};
        vecs[7] = '{16'h9000, 16'h0009, 32'h00081000, 1'b0};
        vecs[8] = '{16'h0999, 16'h0001, 32'h00000999, 1'b0};

        rst = 1'b1;
        drive_in(0, 1'b0, 64'd0, 64'd0);
        drive_in(1, 1'b0, 64'd0, 64'd0);
        set_oready(0, 1'b0);
        set_oready(1, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset in_ready4",  64'(in_ready4),  64'd1);
        check("reset out_valid4", 64'(out_valid4), 64'd0);
        check("reset product4",   64'(prod4),      64'd0);
        check("reset err4",       64'(err4),       64'd0);
        check("reset in_ready8",  64'(in_ready8),  64'd1);
        check("reset out_valid8", 64'(out_valid8), 64'd0);

        // ---------------- table-driven directed vectors (DIGITS=4) ----------
        for (int i = 0; i < 9; i++) begin
            run_job(0, 64'(vecs[i].x), 64'(vecs[i].y), p, e, lat);
            check($sformatf("vec%0d product", i), p, 64'(vecs[i].p));
            check($sformatf("vec%0d err", i), 64'(e), 64'(vecs[i].e));
            check($sformatf("vec%0d latency", i), 64'(lat), vecs[i].e ? 64'd0 : 64'd4);
            check($sformatf("vec%0d in_ready after handshake", i), 64'(in_ready4), 64'd1);
        end

        // ---------------- backpressure: result held, new operands ignored ---
        drive_in(0, 1'b1, 64'h0011, 64'h0011);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 64'h0011, 64'h0011);
        lat = 0;
        while (!out_valid4 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("bp first out_valid", 64'(out_valid4), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) drive_in(0, 1'b1, 64'h9999, 64'h9999);
            if (i == 4) drive_in(0, 1'b0, 64'h9999, 64'h9999);
            @(posedge clk); #1;
            check("bp product",   64'(prod4),      64'h0121);
            check("bp err",       64'(err4),       64'd0);
            check("bp in_ready",  64'(in_ready4),  64'd0);
            check("bp out_valid", 64'(out_valid4), 64'd1);
        end
        set_oready(0, 1'b1);
        @(posedge clk); #1;
        set_oready(0, 1'b0);
        check("bp release out_valid", 64'(out_valid4), 64'd0);
        check("bp release in_ready",  64'(in_ready4),  64'd1);
        repeat (8) @(posedge clk);
        #1 check("bp ignored in_valid", 64'(out_valid4), 64'd0);

        // ---------------- reset in the middle of MUL ------------------------
        drive_in(0, 1'b1, 64'h1234, 64'h5678);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 64'h1234, 64'h5678);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst-mid out_valid", 64'(out_valid4), 64'd0);
        check("rst-mid product",   64'(prod4),      64'd0);
        check("rst-mid in_ready",  64'(in_ready4),  64'd1);
        repeat (6) @(posedge clk);
        #1 check("rst-mid no result", 64'(out_valid4), 64'd0);
        run_job(0, 64'h0025, 64'h0004, p, e, lat);
        check("rst-mid fresh product", p, 64'h00000100);
        check("rst-mid fresh err", 64'(e), 64'd0);

        // ---------------- DIGITS=8 corner -----------------------------------
        run_job(1, 64'h99999999, 64'h99999999, p, e, lat);
        check("d8 max product", p, 64'h9999999800000001);
        check("d8 max err", 64'(e), 64'd0);
        check("d8 max latency", 64'(lat), 64'd8);

        // ---------------- random back-to-back, DIGITS=8 ---------------------
        for (int j = 0; j < 1000; j++) begin
            x = rand_bcd(8);
            y = rand_bcd(8);
            run_job(1, x, y, p, e, lat);
            check($sformatf("d8 rand%0d product x=%0h y=%0h", j, x, y), p, ref_prod(x, y, 8));
            check($sformatf("d8 rand%0d err", j), 64'(e), 64'd0);
        end

        // ---------------- random with occasional illegal nibble, DIGITS=4 ---
        for (int j = 0; j < 200; j++) begin
            x = rand_bcd(4);
            y = rand_bcd(4);
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    x[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
                else
                    y[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            end
            run_job(0, x, y, p, e, lat);
            check($sformatf("d4 rand%0d product x=%0h y=%0h", j, x, y), p, ref_prod(x, y, 4));
            check($sformatf("d4 rand%0d err", j), 64'(e), 64'(ref_err(x, y, 4)));
            check($sformatf("d4 rand%0d latency", j), 64'(lat), ref_err(x, y, 4) ? 64'd0 : 64'd4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
